// File: rtl/leaf_bridge_pkg.sv
// leaf_bridge_pkg
//   Shared definitions for leaf_stream_bridge: the control FSM state encoding
//   and the length of the post-reset / post-flush wait before the kernel runs.
package leaf_bridge_pkg;

  typedef enum logic [1:0] {
    RST_WAIT = 2'd0,
    RUN      = 2'd1,
    FLUSH    = 2'd2
  } bridge_state_e;

  localparam int RST_WAIT_CYCLES = 2;
  localparam int WAIT_CNT_W      = 2;

endpackage

// File: rtl/stream_fifo.sv
// stream_fifo
//   Single-clock vld/ack FIFO, 2**FIFO_DEPTH_BITS entries, no full or empty
//   bypass. A word written into an empty FIFO is visible on the next cycle.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   clear            synchronous empty (pointers and count to zero)
//   enable           gates wr_ack; low means no word is accepted
//   wr_data/wr_vld   write side, wr_ack = not full and enabled
//   rd_data/rd_vld   read side, rd_vld = not empty, rd_data = head (0 when empty)
//   rd_ack           consumer accepts the head word
module stream_fifo #(
  parameter int PAYLOAD_BITS    = 32,
  parameter int FIFO_DEPTH_BITS = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    enable,
  input  logic [PAYLOAD_BITS-1:0] wr_data,
  input  logic                    wr_vld,
  output logic                    wr_ack,
  output logic [PAYLOAD_BITS-1:0] rd_data,
  output logic                    rd_vld,
  input  logic                    rd_ack
);

  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam logic [FIFO_DEPTH_BITS:0] FULL_CNT = (FIFO_DEPTH_BITS+1)'(DEPTH);

  logic [PAYLOAD_BITS-1:0]    mem [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr;
  logic [FIFO_DEPTH_BITS-1:0] rd_ptr;
  logic [FIFO_DEPTH_BITS:0]   count;
  logic                       push;
  logic                       pop;

  // Full refuses a push even when a pop happens in the same cycle.
  assign wr_ack  = enable && (count != FULL_CNT);
  assign rd_vld  = (count != '0);
  // Forcing zero while empty keeps the data output clean after reset/flush.
  assign rd_data = rd_vld ? mem[rd_ptr] : '0;
  assign push    = wr_vld && wr_ack;
  assign pop     = rd_vld && rd_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/leaf_stream_bridge.sv
// leaf_stream_bridge
//   Buffered bridge between the leaf_interface user side and an HLS kernel
//   with ap_vld/ap_ack streams. One FIFO per channel in each direction, an
//   ap_start control FSM (RST_WAIT -> RUN -> FLUSH -> RST_WAIT) and one
//   accepted-word counter per channel.
// Ports:
//   clk_user, reset_n                     clock, asynchronous active-low reset
//   flush                                 one-cycle request, honoured in RUN only
//   dout_leaf_interface2user / vld_interface2user / ack_user2interface
//                                         interface -> bridge, per input channel
//   kernel_in_data / kernel_in_vld / kernel_in_ack
//                                         bridge -> kernel, per input channel
//   kernel_out_data / kernel_out_vld / kernel_out_ack
//                                         kernel -> bridge, per output channel
//   din_leaf_user2interface / vld_user2interface / ack_interface2user
//                                         bridge -> interface, per output channel
//   ap_start                              high while in RUN
//   xfer_count                            per-channel push counters, inputs first
module leaf_stream_bridge
  import leaf_bridge_pkg::*;
#(
  parameter int NUM_IN_PORTS    = 2,
  parameter int NUM_OUT_PORTS   = 2,
  parameter int PAYLOAD_BITS    = 32,
  parameter int FIFO_DEPTH_BITS = 2,
  parameter int COUNT_BITS      = 16
) (
  input  logic                                             clk_user,
  input  logic                                             reset_n,
  input  logic                                             flush,
  input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]             dout_leaf_interface2user,
  input  logic [NUM_IN_PORTS-1:0]                          vld_interface2user,
  output logic [NUM_IN_PORTS-1:0]                          ack_user2interface,
  output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]             kernel_in_data,
  output logic [NUM_IN_PORTS-1:0]                          kernel_in_vld,
  input  logic [NUM_IN_PORTS-1:0]                          kernel_in_ack,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]            kernel_out_data,
  input  logic [NUM_OUT_PORTS-1:0]                         kernel_out_vld,
  output logic [NUM_OUT_PORTS-1:0]                         kernel_out_ack,
  output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]            din_leaf_user2interface,
  output logic [NUM_OUT_PORTS-1:0]                         vld_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]                         ack_interface2user,
  output logic                                             ap_start,
  output logic [(NUM_IN_PORTS+NUM_OUT_PORTS)*COUNT_BITS-1:0] xfer_count
);

  localparam int NCH = NUM_IN_PORTS + NUM_OUT_PORTS;

  bridge_state_e           state;
  bridge_state_e           state_nxt;
  logic [WAIT_CNT_W-1:0]   wait_cnt;
  logic [WAIT_CNT_W-1:0]   wait_nxt;
  logic                    run_en;
  logic                    fifo_clear;
  logic [NCH-1:0]          fifo_push;
  logic [COUNT_BITS-1:0]   xfer_cnt [NCH];

  // Control FSM: state register
  always_ff @(posedge clk_user or negedge reset_n) begin
    if (!reset_n) begin
      state    <= RST_WAIT;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Control FSM: next state. Coming out of async reset the first cycle is
  // spent absorbing the deassertion, so the wait counter starts one lower
  // than it does when re-entering RST_WAIT from FLUSH.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    unique case (state)
      RST_WAIT: begin
        if (wait_cnt == WAIT_CNT_W'(RST_WAIT_CYCLES)) begin
          state_nxt = RUN;
          wait_nxt  = '0;
        end else begin
          wait_nxt  = wait_cnt + 1'b1;
        end
      end
      RUN: begin
        if (flush) state_nxt = FLUSH;
      end
      FLUSH: begin
        state_nxt = RST_WAIT;
        wait_nxt  = WAIT_CNT_W'(1);
      end
      default: begin
        state_nxt = RST_WAIT;
        wait_nxt  = '0;
      end
    endcase
  end

  assign run_en   = (state == RUN);
  assign ap_start = run_en;
  // Clearing on the sampling edge already empties the FIFOs so every vld is
  // low throughout the FLUSH cycle; FLUSH itself clears once more.
  assign fifo_clear = (run_en && flush) || (state == FLUSH);

  for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_in
    stream_fifo #(
      .PAYLOAD_BITS   (PAYLOAD_BITS),
      .FIFO_DEPTH_BITS(FIFO_DEPTH_BITS)
    ) u_fifo (
      .clk    (clk_user),
      .rst_n  (reset_n),
      .clear  (fifo_clear),
      .enable (run_en),
      .wr_data(dout_leaf_interface2user[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .wr_vld (vld_interface2user[i]),
      .wr_ack (ack_user2interface[i]),
      .rd_data(kernel_in_data[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .rd_vld (kernel_in_vld[i]),
      .rd_ack (kernel_in_ack[i])
    );
    assign fifo_push[i] = vld_interface2user[i] && ack_user2interface[i];
  end

  for (genvar j = 0; j < NUM_OUT_PORTS; j++) begin : g_out
    stream_fifo #(
      .PAYLOAD_BITS   (PAYLOAD_BITS),
      .FIFO_DEPTH_BITS(FIFO_DEPTH_BITS)
    ) u_fifo (
      .clk    (clk_user),
      .rst_n  (reset_n),
      .clear  (fifo_clear),
      .enable (run_en),
      .wr_data(kernel_out_data[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .wr_vld (kernel_out_vld[j]),
      .wr_ack (kernel_out_ack[j]),
      .rd_data(din_leaf_user2interface[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .rd_vld (vld_user2interface[j]),
      .rd_ack (ack_interface2user[j])
    );
    assign fifo_push[NUM_IN_PORTS+j] = kernel_out_vld[j] && kernel_out_ack[j];
  end

  // Transfer counters: one per FIFO, wrapping, cleared together with the FIFOs
  always_ff @(posedge clk_user or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NCH; c++) xfer_cnt[c] <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (fifo_clear)        xfer_cnt[c] <= '0;
        else if (fifo_push[c]) xfer_cnt[c] <= xfer_cnt[c] + 1'b1;
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_cnt
    assign xfer_count[c*COUNT_BITS +: COUNT_BITS] = xfer_cnt[c];
  end

endmodule

// File: tb/tb_leaf_stream_bridge.sv
// tb_leaf_stream_bridge
//   Self-checking bench for leaf_stream_bridge at default parameters (DEPTH=4).
//   Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_leaf_stream_bridge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic [63:0] din_if;
  logic [1:0]  vld_if;
  logic [1:0]  ack_u2i;
  logic [63:0] k_in_data;
  logic [1:0]  k_in_vld;
  logic [1:0]  k_in_ack;
  logic [63:0] k_out_data;
  logic [1:0]  k_out_vld;
  logic [1:0]  k_out_ack;
  logic [63:0] din_u2i;
  logic [1:0]  vld_u2i;
  logic [1:0]  ack_i2u;
  logic        ap_start;
  logic [63:0] xfer_count;

  int errors = 0;
  int checks = 0;
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  leaf_stream_bridge dut (
    .clk_user                (clk),
    .reset_n                 (reset_n),
    .flush                   (flush),
    .dout_leaf_interface2user(din_if),
    .vld_interface2user      (vld_if),
    .ack_user2interface      (ack_u2i),
    .kernel_in_data          (k_in_data),
    .kernel_in_vld           (k_in_vld),
    .kernel_in_ack           (k_in_ack),
    .kernel_out_data         (k_out_data),
    .kernel_out_vld          (k_out_vld),
    .kernel_out_ack          (k_out_ack),
    .din_leaf_user2interface (din_u2i),
    .vld_user2interface      (vld_u2i),
    .ack_interface2user      (ack_i2u),
    .ap_start                (ap_start),
    .xfer_count              (xfer_count)
  );

  // Records which channel-0 handshakes happen at the coming edge, then advances.
  task automatic step(output bit in_fire, output bit out_fire, output logic [31:0] out_word);
    in_fire  = vld_if[0] && ack_u2i[0];
    out_fire = k_in_vld[0] && k_in_ack[0];
    out_word = k_in_data[31:0];
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ap_start, ack_u2i} !== 3'b000) begin
      errors++; $display("FAIL reset_hold: ap_start/ack got %b, required 000", {ap_start, ack_u2i});
    end
    reset_n = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk); #1;
      checks++;
      if (ap_start !== (e == 3)) begin
        errors++; $display("FAIL reset_ap_start edge %0d: got %b, required %b", e, ap_start, (e == 3));
      end
      checks++;
      if (ack_u2i !== ((e == 3) ? 2'b11 : 2'b00)) begin
        errors++; $display("FAIL reset_ack edge %0d: got %b, required %b", e, ack_u2i, (e == 3) ? 2'b11 : 2'b00);
      end
      checks++;
      if ({k_in_vld, vld_u2i} !== 4'b0000) begin
        errors++; $display("FAIL reset_vld edge %0d: got %b, required 0000", e, {k_in_vld, vld_u2i});
      end
    end
  endtask

  task automatic test_streaming();
    bit fi, fo;
    logic [31:0] w, exp_w;
    int k, popped;
    k = 0; popped = 0;
    k_in_ack[0] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (k < 8) begin din_if[31:0] = 32'h11 + k; vld_if[0] = 1'b1; end
      else vld_if[0] = 1'b0;
      step(fi, fo, w);
      if (fo) begin
        checks++; popped++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL stream_order: got %h, required no word", w);
        end else begin
          exp_w = sb.pop_front();
          if (w !== exp_w) begin errors++; $display("FAIL stream_order: got %h, required %h", w, exp_w); end
        end
      end
      if (fi) begin
        sb.push_back(din_if[31:0]); k++;
        checks++;
        if (k_in_vld[0] !== 1'b1) begin
          errors++; $display("FAIL stream_latency: kernel_in_vld got %b, required 1", k_in_vld[0]);
        end
      end
    end
    vld_if[0] = 1'b0;
    checks++;
    if (k !== 8 || popped !== 8) begin
      errors++; $display("FAIL stream_count: accepted %0d popped %0d, required 8 8", k, popped);
    end
    checks++;
    if (xfer_count[15:0] !== 16'd8) begin
      errors++; $display("FAIL stream_xfer_count: got %0d, required 8", xfer_count[15:0]);
    end
  endtask

  task automatic test_backpressure();
    bit fi, fo;
    logic [31:0] w, exp_w;
    int k, popped;
    k = 0; popped = 0;
    k_in_ack[0] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      din_if[31:0] = 32'h21 + k; vld_if[0] = 1'b1;
      step(fi, fo, w);
      if (fi) begin sb.push_back(din_if[31:0]); k++; end
    end
    checks++;
    if (k !== 4) begin errors++; $display("FAIL bp_accepted: got %0d, required 4", k); end
    checks++;
    if (ack_u2i[0] !== 1'b0) begin errors++; $display("FAIL bp_ack_full: got %b, required 0", ack_u2i[0]); end
    checks++;
    if (k_in_vld[0] !== 1'b1 || k_in_data[31:0] !== 32'h21) begin
      errors++; $display("FAIL bp_head: vld %b data %h, required 1 00000021", k_in_vld[0], k_in_data[31:0]);
    end
    vld_if[0] = 1'b0;
    k_in_ack[0] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step(fi, fo, w);
      if (fo) begin
        checks++; popped++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL bp_order: got %h, required no word", w);
        end else begin
          exp_w = sb.pop_front();
          if (w !== exp_w) begin errors++; $display("FAIL bp_order: got %h, required %h", w, exp_w); end
        end
      end
    end
    checks++;
    if (popped !== 4 || sb.size() != 0) begin
      errors++; $display("FAIL bp_drain: popped %0d left %0d, required 4 0", popped, sb.size());
    end
    checks++;
    if (xfer_count[15:0] !== 16'd12) begin
      errors++; $display("FAIL bp_xfer_count: got %0d, required 12", xfer_count[15:0]);
    end
  endtask

  task automatic test_full_pop();
    bit fi, fo;
    logic [31:0] w, exp_w;
    int popped;
    popped = 0;
    k_in_ack[0] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      din_if[31:0] = 32'h31 + c; vld_if[0] = 1'b1;
      step(fi, fo, w);
      if (fi) sb.push_back(din_if[31:0]);
    end
    // Full: offer a word while the kernel pops the head in the same cycle.
    din_if[31:0] = 32'h35; vld_if[0] = 1'b1; k_in_ack[0] = 1'b1;
    checks++;
    if (ack_u2i[0] !== 1'b0) begin errors++; $display("FAIL full_refuse: ack got %b, required 0", ack_u2i[0]); end
    step(fi, fo, w);
    if (fi) sb.push_back(din_if[31:0]);
    if (fo) begin
      checks++;
      exp_w = (sb.size() != 0) ? sb.pop_front() : 32'hdead_beef;
      if (w !== 32'h31) begin errors++; $display("FAIL full_pop_word: got %h, required 00000031", w); end
    end
    k_in_ack[0] = 1'b0;
    checks++;
    if (ack_u2i[0] !== 1'b1) begin errors++; $display("FAIL full_count3_ack: got %b, required 1", ack_u2i[0]); end
    din_if[31:0] = 32'h36;
    step(fi, fo, w);
    if (fi) sb.push_back(din_if[31:0]);
    vld_if[0] = 1'b0;
    checks++;
    if (fi !== 1'b1 || ack_u2i[0] !== 1'b0) begin
      errors++; $display("FAIL full_refill: accepted %b ack %b, required 1 0", fi, ack_u2i[0]);
    end
    k_in_ack[0] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step(fi, fo, w);
      if (fo) begin
        checks++; popped++;
        exp_w = (popped == 4) ? 32'h36 : 32'h31 + popped;
        if (w !== exp_w) begin errors++; $display("FAIL full_drain_order: got %h, required %h", w, exp_w); end
      end
    end
    sb.delete();
    checks++;
    if (popped !== 4) begin errors++; $display("FAIL full_drain_count: got %0d, required 4", popped); end
    checks++;
    if (xfer_count[15:0] !== 16'd17) begin
      errors++; $display("FAIL full_xfer_count: got %0d, required 17", xfer_count[15:0]);
    end
  endtask

  task automatic test_flush();
    ack_i2u[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      k_out_data[63:32] = 32'hA1 + c; k_out_vld[1] = 1'b1;
      checks++;
      if (k_out_ack[1] !== 1'b1) begin errors++; $display("FAIL flush_fill_ack %0d: got %b, required 1", c, k_out_ack[1]); end
      @(posedge clk); #1;
    end
    k_out_vld[1] = 1'b0;
    checks++;
    if (vld_u2i[1] !== 1'b1 || din_u2i[63:32] !== 32'hA1) begin
      errors++; $display("FAIL flush_head: vld %b data %h, required 1 000000a1", vld_u2i[1], din_u2i[63:32]);
    end
    checks++;
    if (xfer_count[63:48] !== 16'd3) begin
      errors++; $display("FAIL flush_pre_count: got %0d, required 3", xfer_count[63:48]);
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    ack_i2u[1] = 1'b1;
    checks++;
    if (vld_u2i[1] !== 1'b0) begin errors++; $display("FAIL flush_vld: got %b, required 0", vld_u2i[1]); end
    checks++;
    if (xfer_count !== 64'h0) begin errors++; $display("FAIL flush_counters: got %h, required 0", xfer_count); end
    checks++;
    if ({ap_start, ack_u2i, k_out_ack} !== 5'b00000) begin
      errors++; $display("FAIL flush_ctrl: ap_start/acks got %b, required 00000", {ap_start, ack_u2i, k_out_ack});
    end
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk); #1;
      checks++;
      if (ap_start !== (e == 3)) begin
        errors++; $display("FAIL flush_ap_start +%0d: got %b, required %b", e, ap_start, (e == 3));
      end
      checks++;
      if (vld_u2i !== 2'b00) begin errors++; $display("FAIL flush_stale +%0d: got %b, required 00", e, vld_u2i); end
    end
  endtask

  task automatic test_async_reset();
    k_in_ack = 2'b00; ack_i2u = 2'b00;
    for (int c = 0; c < 2; c++) begin
      din_if[31:0] = 32'h41 + c; vld_if[0] = 1'b1;
      k_out_data[31:0] = 32'hB1 + c; k_out_vld[0] = 1'b1;
      @(posedge clk); #1;
    end
    vld_if[0] = 1'b0; k_out_vld[0] = 1'b0;
    checks++;
    if (k_in_vld[0] !== 1'b1 || vld_u2i[0] !== 1'b1) begin
      errors++; $display("FAIL arst_pre: vld got %b %b, required 1 1", k_in_vld[0], vld_u2i[0]);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({ap_start, ack_u2i, k_out_ack, k_in_vld, vld_u2i} !== 9'b0) begin
      errors++; $display("FAIL arst_ctrl: got %b, required 000000000", {ap_start, ack_u2i, k_out_ack, k_in_vld, vld_u2i});
    end
    checks++;
    if (k_in_data !== 64'h0 || din_u2i !== 64'h0) begin
      errors++; $display("FAIL arst_data: got %h %h, required 0 0", k_in_data, din_u2i);
    end
    k_in_ack = 2'b11; ack_i2u = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ap_start !== 1'b1 || xfer_count !== 64'h0) begin
      errors++; $display("FAIL arst_restart: ap_start %b count %h, required 1 0", ap_start, xfer_count);
    end
    for (int e = 0; e < 3; e++) begin
      checks++;
      if ({k_in_vld, vld_u2i} !== 4'b0000) begin
        errors++; $display("FAIL arst_stale %0d: got %b, required 0000", e, {k_in_vld, vld_u2i});
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0;
    din_if = '0; vld_if = '0; k_in_ack = '0;
    k_out_data = '0; k_out_vld = '0; ack_i2u = '0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_full_pop();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/leaf_stream_bridge.md
# leaf_stream_bridge

Parametrised buffered bridge between the user side of `leaf_interface` and an HLS kernel with `ap_vld`/`ap_ack` streams, in the `clk_user` domain of a leaf. It generalises the fixed two-in/two-out direct wiring to any channel count. Each direction has a per-channel FIFO that decouples kernel stalls from the interface. The block also generates `ap_start` from a small control FSM, supports a synchronous flush, and exposes per-channel transfer counters.

## Interface
- `NUM_IN_PORTS`, default 2: interface→kernel channels (1..15).
- `NUM_OUT_PORTS`, default 2: kernel→interface channels (1..15).
- `PAYLOAD_BITS`, default 32: data width per channel.
- `FIFO_DEPTH_BITS`, default 2: log2 FIFO depth per channel (DEPTH = 2**FIFO_DEPTH_BITS).
- `COUNT_BITS`, default 16: width of each transfer counter.

Ports:
- `clk_user`, in, 1: single clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `flush`, in, 1: synchronous one-cycle request to empty all FIFOs and restart the kernel.
- `dout_leaf_interface2user`, in, NUM_IN_PORTS*PAYLOAD_BITS: interface data (channel i at bits [i*PAYLOAD_BITS +: PAYLOAD_BITS]).
- `vld_interface2user`, in, NUM_IN_PORTS: interface valid.
- `ack_user2interface`, out, NUM_IN_PORTS: bridge accepts.
- `kernel_in_data`, out, NUM_IN_PORTS*PAYLOAD_BITS: kernel input data.
- `kernel_in_vld`, out, NUM_IN_PORTS: kernel input valid.
- `kernel_in_ack`, in, NUM_IN_PORTS: kernel accepts.
- `kernel_out_data`, in, NUM_OUT_PORTS*PAYLOAD_BITS: kernel output data.
- `kernel_out_vld`, in, NUM_OUT_PORTS: kernel output valid.
- `kernel_out_ack`, out, NUM_OUT_PORTS: bridge accepts.
- `din_leaf_user2interface`, out, NUM_OUT_PORTS*PAYLOAD_BITS: data to interface.
- `vld_user2interface`, out, NUM_OUT_PORTS: valid to interface.
- `ack_interface2user`, in, NUM_OUT_PORTS: interface accepts.
- `ap_start`, out, 1: kernel start.
- `xfer_count`, out, (NUM_IN_PORTS+NUM_OUT_PORTS)*COUNT_BITS: accepted-word counters, input channels first.

## Operation
- **Transfer rule:** a transfer occurs on any edge where vld and ack are both high. Data is sampled with vld, and vld never depends combinationally on ack.
- **Per-channel FIFO:**
  - ack = (count != DEPTH) && state==RUN.
  - Output vld = (count != 0); data is the head entry.
  - Simultaneous push and pop with 0<count<DEPTH keeps count unchanged.
  - At count==DEPTH, push is refused even if a pop occurs that cycle (no full-bypass).
  - At count==0 there is no empty-bypass: a written word first appears next cycle.
  - Read/write pointers are FIFO_DEPTH_BITS wide and wrap modulo DEPTH; count is FIFO_DEPTH_BITS+1 wide.
- **Counters:** each counter increments on every accepted push into its FIFO, wraps modulo 2**COUNT_BITS, and clears on flush.
- **FSM states:**
  - RST_WAIT: after reset, holds 2 cycles, then goes to RUN.
  - RUN: `ap_start`=1, all acks enabled; flush → FLUSH.
  - FLUSH: one cycle. All FIFOs and counters are cleared, `ap_start`=0, all acks and vlds are 0. Always returns to RST_WAIT.
  - A flush asserted in RST_WAIT or FLUSH is ignored.
- **Reset (async, any time):**
  - All FIFOs empty, counters 0, state RST_WAIT.
  - Outputs: `ap_start`=0, all ack=0, all vld=0, data outputs 0.
  - Words in flight are discarded.

## Timing
- Interface-to-kernel latency: a word pushed at edge N drives vld at edge N+1, i.e. 1 cycle.
- Sustained throughput is 1 word/cycle/channel while neither side stalls.
- After `reset_n` rises, ack and `ap_start` first go high at the 3rd rising edge.
- After flush is sampled in RUN, acks drop in the next cycle; RUN resumes 3 cycles after the FLUSH cycle.
- All outputs are registered or derived only from registered state.

## Structure
- Package `leaf_bridge_pkg`: FSM state enum (RST_WAIT, RUN, FLUSH) and the constant RST_WAIT_CYCLES = 2.
- Sub-module `stream_fifo` (PAYLOAD_BITS, FIFO_DEPTH_BITS) with clear input. It is instantiated NUM_IN_PORTS+NUM_OUT_PORTS times via generate.
- The top level contains the FSM, the counters and the slicing of the flattened buses.

## Test plan
All scenarios use defaults, so DEPTH=4.
- **Reset release:** `reset_n` low→high → `ap_start`, ack_user2interface=2'b11 at the 3rd edge; all vld 0 until then.
- **Streaming:** in channel 0 words 0x11..0x18 with `kernel_in_ack`=1 constantly → same order on `kernel_in_data`[31:0], each 1 cycle later; xfer_count[15:0]=8.
- **Backpressure:** `kernel_in_ack`=0, 6 words offered → exactly 4 accepted and ack_user2interface[0]=0; releasing ack delivers 4 words in order.
- **Full with simultaneous pop:** at count 4, with push and pop on the same cycle → push refused and count 3.
- **Flush mid-stream:** out channel 1 holds 3 words and flush pulses → vld_user2interface[1]=0 next cycle; counters 0; `ap_start` low for 3 cycles.
- **Async reset mid-burst:** `reset_n` low with FIFOs half full → outputs 0 immediately without a clock edge; after release no stale word appears.
